// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, runtime prescaler, mid-bit sampling, one-byte holding register.
// Reports stop-bit errors and dropped bytes as single-cycle pulses.
module uart_rx #(
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rstz,
    input  logic                       rx,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    output logic [7:0]                 dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic                       frame_err,
    output logic                       overrun,
    output logic [2:0]                 fsm_state
);

    // Handshake: a byte transfers on any cycle where dout_vld && dout_rdy are both high;
    // dout_vld never drops and dout never changes until that transfer happens.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       rx_meta;
    logic                       rx_s;
    logic [PRESCALER_WIDTH-1:0] timer;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 shreg;
    logic                       full_tick;
    logic                       half_tick;
    logic                       timer_clr;
    logic                       bit_clr;
    logic                       shift_en;
    logic                       deliver;
    logic                       stop_err;

    assign full_tick = (timer == prescaler);
    assign half_tick = (timer == (prescaler >> 1));
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        stop_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    timer_clr = 1'b1;
                end
            end
            START: begin
                // A start bit that is high again at its mid-point was only a glitch.
                if (half_tick) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        timer_clr = 1'b1;
                        bit_clr   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_err  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            timer   <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (state == IDLE || timer_clr || full_tick) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (bit_clr) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            // LSB arrives first, so shifting in at the MSB leaves bit 0 in place after eight samples.
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            dout      <= 8'h00;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= deliver && dout_vld && !dout_rdy;
            if (deliver && (!dout_vld || dout_rdy)) begin
                dout     <= shreg;
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver tasks, expected-byte queue scoreboard,
// pulse counters for frame_err/overrun, and a single summary line.
module tb_uart_rx;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rstz;
    logic          rx;
    logic [PW-1:0] prescaler;
    logic [7:0]    dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic          frame_err;
    logic          overrun;
    logic [2:0]    fsm_state;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;
    int rx_cnt   = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uart_rx #(.PRESCALER_WIDTH(PW)) dut (
        .clk       (clk),
        .rstz      (rstz),
        .rx        (rx),
        .prescaler (prescaler),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rstz) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) check("err_exclusive", {30'd0, frame_err, overrun}, 32'd2);
            if (prev_hold) check("dout_stable", {24'd0, dout}, {24'd0, prev_dout});
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("rx_byte", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                end
                rx_cnt++;
            end
            prev_hold = dout_vld && !dout_rdy;
            prev_dout = dout;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Driver tasks: every task starts and ends on a falling edge
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (int'(prescaler) + 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * (int'(prescaler) + 1)) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int base;
        logic [7:0] b;
        rstz      = 1'b0;
        rx        = 1'b1;
        prescaler = 16'd3;
        dout_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_vld", {31'd0, dout_vld}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        check("rst_state", {29'd0, fsm_state}, 32'd0);
        rstz = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_state", {29'd0, fsm_state}, 32'd0);

        // 0xA5 at prescaler 3, with latency from the falling edge to dout_vld
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!dout_vld && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        $display("latency = %0d cycles", lat);
        check("latency_in_window", {31'd0, (lat >= 40 && lat <= 42)}, 32'd1);
        idle_bits(3);
        wait_drain();
        check("a5_count", 32'(rx_cnt), 32'd1);

        // Back-to-back frames at prescaler 15
        prescaler = 16'd15;
        idle_bits(2);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle_bits(2);
        wait_drain();
        check("b2b_count", 32'(rx_cnt), 32'd4);

        // Short glitch is rejected at the start-bit mid-point
        prescaler = 16'd7;
        idle_bits(2);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", {29'd0, fsm_state}, 32'd0);
        check("glitch_vld", {31'd0, dout_vld}, 32'd0);
        check("glitch_count", 32'(rx_cnt), 32'd4);

        // Bad stop bit, then recovery with a good frame
        send_byte(8'h3C, 1'b0);
        exp_fe++;
        idle_bits(3);
        check("fe_state", {29'd0, fsm_state}, 32'd0);
        check("fe_count", 32'(fe_cnt), 32'(exp_fe));
        check("fe_vld", {31'd0, dout_vld}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        idle_bits(2);
        wait_drain();
        check("after_fe_count", 32'(rx_cnt), 32'd5);

        // Overrun while the holding register is full
        prescaler = 16'd3;
        dout_rdy  = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        exp_ov++;
        idle_bits(3);
        check("ovr_dout", {24'd0, dout}, 32'h11);
        check("ovr_vld", {31'd0, dout_vld}, 32'd1);
        check("ovr_count", 32'(ov_cnt), 32'(exp_ov));
        @(posedge clk);
        #1 dout_rdy = 1'b1;
        @(negedge clk);
        wait_drain();
        exp_q.push_back(8'h33);
        send_byte(8'h33, 1'b1);
        idle_bits(2);
        wait_drain();
        check("ovr_rx_count", 32'(rx_cnt), 32'd7);

        // Reset in the middle of bit D3 of 0x77
        prescaler = 16'd7;
        b = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        repeat (3) @(negedge clk);
        rstz = 1'b0;
        rx   = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_state", {29'd0, fsm_state}, 32'd0);
        rstz = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_idle", {29'd0, fsm_state}, 32'd0);
        check("midrst_vld", {31'd0, dout_vld}, 32'd0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        idle_bits(2);
        wait_drain();
        check("midrst_count", 32'(rx_cnt), 32'd8);

        // Random bytes at a random prescaler
        prescaler = 16'($urandom_range(2, 12));
        idle_bits(2);
        base = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b, 1'b1);
        end
        idle_bits(2);
        wait_drain();
        check("rand_count", 32'(rx_cnt - base), 32'd4);

        check("final_fe", 32'(fe_cnt), 32'(exp_fe));
        check("final_ov", 32'(ov_cnt), 32'(exp_ov));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
